// File: rtl/iir_dsp_pkg.sv
// ----------------------------------------------------------------------------
// iir_dsp_pkg
// Shared definitions for the IIR signal chain (iir_filter, iir_decimator).
// Holds the decimator FSM state type, derived-width helpers and the
// saturation bound helpers used by every round/saturate output stage.
// No ports (package).
// ----------------------------------------------------------------------------
package iir_dsp_pkg;

    // Decimator phases: ACCUM collects samples, DUMP waits for the last
    // sample of the block and emits the averaged result when it arrives.
    typedef enum logic {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } decim_state_t;

    // Accumulator width: summing 2^log2_ratio words of nb_in bits grows the
    // magnitude by log2_ratio bits, so this width can never overflow.
    function automatic int acc_width(input int nb_in, input int log2_ratio);
        return nb_in + log2_ratio;
    endfunction

    // Alignment shift between fraction formats; positive means bits are
    // dropped (right shift with rounding), negative means a left shift.
    function automatic int align_shift(input int nbf_in, input int nbf_out);
        return nbf_in - nbf_out;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Largest / smallest two's complement value representable in nb bits,
    // returned wide so callers can size-cast into their working width.
    function automatic logic signed [63:0] sat_max(input int nb);
        return (64'sd1 <<< (nb - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int nb);
        return -(64'sd1 <<< (nb - 1));
    endfunction

endpackage

// File: rtl/iir_decimator_round_sat.sv
// ----------------------------------------------------------------------------
// round_sat
// Combinational re-formatting stage: converts a signed fixed-point word from
// Q(NB_IN-NBF_IN).NBF_IN to Q(NB_OUT-NBF_OUT).NBF_OUT. Dropped fraction bits
// are rounded half-up (add half an output LSB, arithmetic shift right); added
// fraction bits are a plain left shift. The result is clamped to the output
// range.
// Ports:
//   in_word   in   NB_IN   signed input word
//   out_word  out  NB_OUT  rounded, aligned, saturated word
//   sat_hit   out  1       high when the clamp changed the value
// ----------------------------------------------------------------------------
module round_sat
    import iir_dsp_pkg::*;
#(
    parameter int NB_IN   = 17,
    parameter int NBF_IN  = 15,
    parameter int NB_OUT  = 16,
    parameter int NBF_OUT = 15
) (
    input  logic signed [NB_IN-1:0]  in_word,
    output logic signed [NB_OUT-1:0] out_word,
    output logic                     sat_hit
);

    localparam int SHIFT = align_shift(NBF_IN, NBF_OUT);
    localparam int RSH   = (SHIFT > 0) ? SHIFT : 0;
    localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;

    // Working width leaves room for the rounding carry, the left shift and a
    // sign bit above the output range so the clamp compare is exact.
    localparam int NB_W  = max_int(NB_IN + 1 + LSH, NB_OUT + 1);

    localparam logic signed [NB_W-1:0] SAT_MAX_W = NB_W'(sat_max(NB_OUT));
    localparam logic signed [NB_W-1:0] SAT_MIN_W = NB_W'(sat_min(NB_OUT));

    logic signed [NB_W-1:0] ext;
    logic signed [NB_W-1:0] aligned;

    assign ext = {{(NB_W-NB_IN){in_word[NB_IN-1]}}, in_word};

    // Fraction alignment: round half-up when dropping bits, shift when adding.
    generate
        if (RSH > 0) begin : g_round
            localparam logic signed [NB_W-1:0] HALF = {{(NB_W-1){1'b0}}, 1'b1} << (RSH - 1);
            logic signed [NB_W-1:0] biased;
            assign biased  = ext + HALF;
            assign aligned = biased >>> RSH;
        end else if (LSH > 0) begin : g_left
            assign aligned = ext <<< LSH;
        end else begin : g_pass
            assign aligned = ext;
        end
    endgenerate

    // Clamp to the output word's two's complement range.
    always_comb begin
        out_word = aligned[NB_OUT-1:0];
        sat_hit  = 1'b0;
        if (aligned > SAT_MAX_W) begin
            out_word = SAT_MAX_W[NB_OUT-1:0];
            sat_hit  = 1'b1;
        end else if (aligned < SAT_MIN_W) begin
            out_word = SAT_MIN_W[NB_OUT-1:0];
            sat_hit  = 1'b1;
        end
    end

endmodule

// File: rtl/iir_decimator.sv
// ----------------------------------------------------------------------------
// iir_decimator
// Accumulate-and-dump decimator placed after iir_filter. Averages each block
// of 2^LOG2_DECIM accepted samples, rounds the mean half-up, converts it to
// the output Q format, saturates, and emits one sample per block.
// Optional build macro: IIR_DECIM_SAT_FLAG_EN adds the sticky o_sat flag.
// Ports:
//   clock     in   1            system clock, all state on rising edge
//   i_reset   in   1            synchronous active-high reset
//   i_enable  in   1            sample-valid qualifier
//   i_data    in   NB_DATA_IN   signed input sample
//   o_data    out  NB_DATA_OUT  decimated sample, held between strobes
//   o_valid   out  1            one-cycle strobe marking a new o_data
//   o_sat     out  1            sticky clamp flag (IIR_DECIM_SAT_FLAG_EN only)
// ----------------------------------------------------------------------------
module iir_decimator
    import iir_dsp_pkg::*;
#(
    parameter int NB_DATA_IN   = 16,
    parameter int NBF_DATA_IN  = 15,
    parameter int NB_DATA_OUT  = 16,
    parameter int NBF_DATA_OUT = 15,
    parameter int LOG2_DECIM   = 3
) (
    input  logic                          clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic signed [NB_DATA_IN-1:0]  i_data,
    output logic signed [NB_DATA_OUT-1:0] o_data,
    output logic                          o_valid
`ifdef IIR_DECIM_SAT_FLAG_EN
    ,
    output logic                          o_sat
`endif
);

    localparam int NB_ACC  = acc_width(NB_DATA_IN, LOG2_DECIM);
    localparam int NB_MEAN = NB_DATA_IN + 1;

    // Count value of the second-to-last sample; accepting it arms DUMP.
    localparam logic [LOG2_DECIM-1:0] CNT_PRE_LAST = LOG2_DECIM'((1 << LOG2_DECIM) - 2);

    decim_state_t                 state;
    logic [LOG2_DECIM-1:0]        sample_count;
    logic signed [NB_ACC-1:0]     acc;
    logic signed [NB_ACC-1:0]     data_ext;
    logic signed [NB_ACC-1:0]     sum;
    logic signed [NB_MEAN-1:0]    mean;
    logic signed [NB_DATA_OUT-1:0] rounded;
    logic                         mean_sat;
    logic                         out_sat;

    // Running sum including the sample currently on the input; on the DUMP
    // edge this is the full block total.
    assign data_ext = {{LOG2_DECIM{i_data[NB_DATA_IN-1]}}, i_data};
    assign sum      = acc + data_ext;

    // Divide by the block length with round-half-up. The mean of in-range
    // samples always fits NB_DATA_IN+1 bits, so this stage never clamps.
    round_sat #(
        .NB_IN   (NB_ACC),
        .NBF_IN  (NBF_DATA_IN + LOG2_DECIM),
        .NB_OUT  (NB_MEAN),
        .NBF_OUT (NBF_DATA_IN)
    ) mean_stage (
        .in_word  (sum),
        .out_word (mean),
        .sat_hit  (mean_sat)
    );

    // Re-format the mean into the output Q format and saturate.
    round_sat #(
        .NB_IN   (NB_MEAN),
        .NBF_IN  (NBF_DATA_IN),
        .NB_OUT  (NB_DATA_OUT),
        .NBF_OUT (NBF_DATA_OUT)
    ) out_stage (
        .in_word  (mean),
        .out_word (rounded),
        .sat_hit  (out_sat)
    );

`ifndef IIR_DECIM_SAT_FLAG_EN
    logic sat_unused;
    assign sat_unused = mean_sat | out_sat;
`endif

    // Block FSM with registered outputs. ACCUM adds each accepted sample;
    // once the second-to-last sample is in, the FSM sits in DUMP until the
    // final sample arrives, then registers the result, pulses o_valid and
    // restarts with a clean accumulator. Idle cycles hold everything.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state        <= ACCUM;
            sample_count <= '0;
            acc          <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
`ifdef IIR_DECIM_SAT_FLAG_EN
            o_sat        <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
            if (i_enable) begin
                case (state)
                    ACCUM: begin
                        acc          <= sum;
                        sample_count <= sample_count + LOG2_DECIM'(1);
                        if (sample_count == CNT_PRE_LAST) begin
                            state <= DUMP;
                        end
                    end
                    DUMP: begin
                        acc          <= '0;
                        sample_count <= '0;
                        o_data       <= rounded;
                        o_valid      <= 1'b1;
`ifdef IIR_DECIM_SAT_FLAG_EN
                        if (mean_sat || out_sat) begin
                            o_sat <= 1'b1;
                        end
`endif
                        state        <= ACCUM;
                    end
                    default: state <= ACCUM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iir_decimator.sv
// ----------------------------------------------------------------------------
// tb_iir_decimator
// Self-checking bench for iir_decimator. Two instances share the stimulus:
// dut_a uses the default Q1.15 -> Q1.15 formats, dut_b takes Q2.14 input so
// large averages clamp. A block-average reference model predicts every cycle.
// ----------------------------------------------------------------------------
module tb_iir_decimator;

    localparam int LOG2_DECIM = 3;
    localparam int R          = 1 << LOG2_DECIM;

    logic               clock = 1'b0;
    logic               i_reset;
    logic               i_enable;
    logic signed [15:0] i_data;
    logic signed [15:0] data_a;
    logic signed [15:0] data_b;
    logic               valid_a;
    logic               valid_b;
`ifdef IIR_DECIM_SAT_FLAG_EN
    logic               sat_a;
    logic               sat_b;
`endif

    int checks   = 0;
    int failures = 0;

    longint      model_sum;
    int          model_cnt;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_valid;
    logic        exp_sat_a;
    logic        exp_sat_b;

    iir_decimator #(
        .NB_DATA_IN(16), .NBF_DATA_IN(15), .NB_DATA_OUT(16), .NBF_DATA_OUT(15),
        .LOG2_DECIM(LOG2_DECIM)
    ) dut_a (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_data   (i_data),
        .o_data   (data_a),
        .o_valid  (valid_a)
`ifdef IIR_DECIM_SAT_FLAG_EN
        ,
        .o_sat    (sat_a)
`endif
    );

    iir_decimator #(
        .NB_DATA_IN(16), .NBF_DATA_IN(14), .NB_DATA_OUT(16), .NBF_DATA_OUT(15),
        .LOG2_DECIM(LOG2_DECIM)
    ) dut_b (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_data   (i_data),
        .o_data   (data_b),
        .o_valid  (valid_b)
`ifdef IIR_DECIM_SAT_FLAG_EN
        ,
        .o_sat    (sat_b)
`endif
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Mathematical floor division (rounds toward minus infinity).
    function automatic longint floorDiv(input longint n, input longint dv);
        if (n >= 0) return n / dv;
        return -((-n + dv - 1) / dv);
    endfunction

    // Reference result for a block total: mean rounded half-up, converted
    // from nbf_in to 15 fraction bits, clamped to 16-bit signed.
    function automatic logic [15:0] modelOut(input longint sum, input int nbf_in, output logic hit);
        longint mean;
        longint v;
        mean = floorDiv(sum + R / 2, R);
        if (nbf_in < 15) begin
            v = mean * (longint'(1) << (15 - nbf_in));
        end else if (nbf_in > 15) begin
            v = floorDiv(mean + (longint'(1) << (nbf_in - 16)), longint'(1) << (nbf_in - 15));
        end else begin
            v = mean;
        end
        hit = 1'b0;
        if (v > 32767) begin
            v   = 32767;
            hit = 1'b1;
        end else if (v < -32768) begin
            v   = -32768;
            hit = 1'b1;
        end
        return v[15:0];
    endfunction

    // Advance the reference by one clock edge with the given inputs.
    task automatic modelStep(input logic rst, input logic en, input logic [15:0] d);
        logic hit_a;
        logic hit_b;
        if (rst) begin
            model_sum = 0;
            model_cnt = 0;
            exp_a     = 16'h0000;
            exp_b     = 16'h0000;
            exp_valid = 1'b0;
            exp_sat_a = 1'b0;
            exp_sat_b = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (en) begin
                model_sum += longint'($signed(d));
                model_cnt++;
                if (model_cnt == R) begin
                    exp_a     = modelOut(model_sum, 15, hit_a);
                    exp_b     = modelOut(model_sum, 14, hit_b);
                    exp_sat_a = exp_sat_a | hit_a;
                    exp_sat_b = exp_sat_b | hit_b;
                    exp_valid = 1'b1;
                    model_sum = 0;
                    model_cnt = 0;
                end
            end
        end
    endtask

    task automatic checkBits(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string phase);
        checkBits({phase, " data_a"},  data_a,  exp_a);
        checkBits({phase, " valid_a"}, {15'd0, valid_a}, {15'd0, exp_valid});
        checkBits({phase, " data_b"},  data_b,  exp_b);
        checkBits({phase, " valid_b"}, {15'd0, valid_b}, {15'd0, exp_valid});
`ifdef IIR_DECIM_SAT_FLAG_EN
        checkBits({phase, " sat_a"}, {15'd0, sat_a}, {15'd0, exp_sat_a});
        checkBits({phase, " sat_b"}, {15'd0, sat_b}, {15'd0, exp_sat_b});
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare.
    task automatic applyStimulus(input logic rst, input logic en, input logic [15:0] d, input string phase);
        i_reset  = rst;
        i_enable = en;
        i_data   = d;
        modelStep(rst, en, d);
        @(posedge clock);
        #1;
        checkOutput(phase);
    endtask

    task automatic feedBlock(input logic [15:0] first, input logic [15:0] rest, input string phase);
        applyStimulus(1'b0, 1'b1, first, phase);
        for (int k = 1; k < R; k++) applyStimulus(1'b0, 1'b1, rest, phase);
    endtask

    initial begin
        i_reset  = 1'b1;
        i_enable = 1'b1;
        i_data   = 16'h4000;
        model_sum = 0;
        model_cnt = 0;

        // Reset dominates a busy input stream.
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 16'h4000, "reset");
        checkBits("reset data", data_a, 16'h0000);

        // Constant blocks, single and back-to-back.
        feedBlock(16'h1000, 16'h1000, "const8");
        checkBits("const8 data", data_a, 16'h1000);
        checkBits("const8 strobe", {15'd0, valid_a}, 16'h0001);
        applyStimulus(1'b0, 1'b0, 16'h0000, "idle");
        applyStimulus(1'b0, 1'b0, 16'h0000, "idle");
        feedBlock(16'h1000, 16'h1000, "const16");
        feedBlock(16'h1000, 16'h1000, "const16");

        // Round-half-up boundaries.
        feedBlock(16'h0004, 16'h0000, "round+4");
        checkBits("round+4 data", data_a, 16'h0001);
        feedBlock(16'h0003, 16'h0000, "round+3");
        checkBits("round+3 data", data_a, 16'h0000);
        feedBlock(16'hFFFC, 16'h0000, "round-4");
        checkBits("round-4 data", data_a, 16'h0000);
        feedBlock(16'hFFFB, 16'h0000, "round-5");
        checkBits("round-5 data", data_a, 16'hFFFF);

        // Gapped enable: every other cycle.
        for (int k = 0; k < 2 * R * 2; k++)
            applyStimulus(1'b0, logic'(k % 2 == 0), 16'h2000, "gapped");
        checkBits("gapped data", data_a, 16'h2000);

        // Reset in the middle of a block discards the partial sum.
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 16'h7000, "midrst");
        applyStimulus(1'b1, 1'b0, 16'h0000, "midrst");
        feedBlock(16'h0100, 16'h0100, "midrst");
        checkBits("midrst data", data_a, 16'h0100);

        // 1.5 in Q2.14 clamps in dut_b; the flag must stay set afterwards.
        feedBlock(16'h6000, 16'h6000, "sat");
        checkBits("sat data_b", data_b, 16'h7FFF);
        feedBlock(16'h1000, 16'h1000, "after_sat");
        checkBits("after_sat data_b", data_b, 16'h2000);
`ifdef IIR_DECIM_SAT_FLAG_EN
        checkBits("sticky sat_b", {15'd0, sat_b}, 16'h0001);
`endif
        applyStimulus(1'b1, 1'b0, 16'h0000, "satclr");

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 400; k++)
            applyStimulus(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 3) != 0),
                          16'($urandom), "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
